// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq_if (with cpu_types_pkg)
//  Description : ALU op encoding and the request/result/ALU bundle of muldiv_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;
endpackage

interface muldiv_seq_if;
  import cpu_types_pkg::*;

  logic        start;
  logic [1:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        kill;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;
  aluop_t      alu_aluop;
  logic [31:0] alu_portA;
  logic [31:0] alu_portB;
  logic [31:0] alu_outputPort;

  // master: pipeline plus the shared ALU; slave: the sequencer
  modport master (
    output start, op, opA, opB, kill, alu_outputPort,
    input  busy, done, div0, hi, lo, alu_aluop, alu_portA, alu_portB
  );
  modport slave (
    input  start, op, opA, opB, kill, alu_outputPort,
    output busy, done, div0, hi, lo, alu_aluop, alu_portA, alu_portB
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Multi-cycle shift-add multiply / restoring divide on a shared
//                ALU port. Signed ops enabled by defining SIGNED_MULDIV_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
  import cpu_types_pkg::*;
#(
  parameter int          WORD_W    = 32,
  parameter logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF
) (
  input logic         CLK,
  input logic         nRST,
  muldiv_seq_if.slave bus
);

`ifdef SIGNED_MULDIV_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif
  localparam int               CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE1  = 3'd1,
    S_PRE2  = 3'd2,
    S_RUN   = 3'd3,
    S_POST1 = 3'd4,
    S_POST2 = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_acc, r_q, r_m, r_hi, r_lo;
  logic [31:0]      w_acc_nxt, w_q_nxt, w_m_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_is_div, r_sgn, r_sa, r_sb, r_div0;
  aluop_t           w_aluop;
  logic [31:0]      w_pa, w_pb, w_s, w_rs, w_mul_b;
  logic             w_req_div, w_req_sgn, w_accept, w_c, w_borrow, w_ok, w_neg_lo;

  assign w_s       = bus.alu_outputPort;
  assign w_req_div = bus.op[0];
  assign w_req_sgn = SGN_EN & bus.op[1];
  assign w_accept  = (r_state == S_IDLE) & bus.start & ~bus.kill;
  assign w_neg_lo  = r_sa ^ r_sb;

  // Multiply step: carry out of P_hi + (P_lo[0] ? M : 0)
  assign w_mul_b = r_q[0] ? r_m : 32'd0;
  assign w_c     = (r_acc[31] & w_mul_b[31]) | ((r_acc[31] | w_mul_b[31]) & ~w_s[31]);

  // Divide step: 33-bit partial remainder {r_acc[31], w_rs} minus divisor
  assign w_rs     = {r_acc[30:0], r_q[31]};
  assign w_borrow = (~w_rs[31] & r_m[31]) | ((~w_rs[31] | r_m[31]) & w_s[31]);
  assign w_ok     = r_acc[31] | ~w_borrow;

  // ALU drive depends on registered state only, so the external ALU never loops back
  always_comb begin
    w_aluop = ALU_ADD;
    w_pa    = 32'd0;
    w_pb    = 32'd0;
    case (r_state)
      S_PRE1: begin
        w_aluop = ALU_SUB;
        w_pb    = r_is_div ? r_q : r_m;
      end
      S_PRE2: begin
        w_aluop = ALU_SUB;
        w_pb    = r_is_div ? r_m : r_q;
      end
      S_RUN: begin
        if (r_is_div) begin
          w_aluop = ALU_SUB;
          w_pa    = w_rs;
          w_pb    = r_m;
        end else begin
          w_pa = r_acc;
          w_pb = w_mul_b;
        end
      end
      S_POST1: begin
        w_aluop = ALU_SUB;
        w_pb    = r_q;
      end
      S_POST2: begin
        if (r_is_div) begin
          w_aluop = ALU_SUB;
          w_pb    = r_acc;
        end else begin
          w_pa = ~r_acc;
          w_pb = {31'd0, r_q == 32'd0};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_q_nxt     = r_q;
    w_m_nxt     = r_m;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt = CNT_INIT;
          w_acc_nxt = 32'd0;
          w_q_nxt   = w_req_div ? bus.opA : bus.opB;
          w_m_nxt   = w_req_div ? bus.opB : bus.opA;
          if (w_req_div && bus.opB == 32'd0) begin
            w_state_nxt = S_DONE;
            w_acc_nxt   = bus.opA;
            w_q_nxt     = DIV0_QUOT;
          end else begin
            w_state_nxt = w_req_sgn ? S_PRE1 : S_RUN;
          end
        end
      end
      S_PRE1: begin
        if (r_sa) begin
          if (r_is_div) w_q_nxt = w_s;
          else          w_m_nxt = w_s;
        end
        w_state_nxt = S_PRE2;
      end
      S_PRE2: begin
        if (r_sb) begin
          if (r_is_div) w_m_nxt = w_s;
          else          w_q_nxt = w_s;
        end
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (r_is_div) begin
          w_acc_nxt = w_ok ? w_s : w_rs;
          w_q_nxt   = {r_q[30:0], w_ok};
        end else begin
          w_acc_nxt = {w_c, w_s[31:1]};
          w_q_nxt   = {w_s[0], r_q[31:1]};
        end
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == '0) w_state_nxt = r_sgn ? S_POST1 : S_DONE;
      end
      S_POST1: begin
        if (w_neg_lo) w_q_nxt = w_s;
        w_state_nxt = S_POST2;
      end
      S_POST2: begin
        if (r_is_div ? r_sa : w_neg_lo) w_acc_nxt = w_s;
        w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // A flush arriving in DONE loses to the completing result
    if (bus.kill && r_state != S_IDLE && r_state != S_DONE) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= S_IDLE;
      r_acc    <= 32'd0;
      r_q      <= 32'd0;
      r_m      <= 32'd0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_sgn    <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_div0   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_q     <= w_q_nxt;
      r_m     <= w_m_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_is_div <= w_req_div;
        r_sgn    <= w_req_sgn;
        r_sa     <= w_req_sgn & bus.opA[31];
        r_sb     <= w_req_sgn & bus.opB[31];
      end
      // Results publish on the edge entering DONE so they are valid with done
      if (w_state_nxt == S_DONE) begin
        r_hi <= w_acc_nxt;
        r_lo <= w_q_nxt;
        if (r_state == S_IDLE) r_div0 <= 1'b1;
        else if (r_is_div)     r_div0 <= 1'b0;
      end
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.div0      = r_div0;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.alu_aluop = w_aluop;
  assign bus.alu_portA = w_pa;
  assign bus.alu_portB = w_pb;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_seq
//  Description : Table-driven and scoreboard bench for muldiv_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;
  import cpu_types_pkg::*;

`ifdef SIGNED_MULDIV_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRST;

  muldiv_seq_if bus ();

  muldiv_seq #(.WORD_W(32), .DIV0_QUOT(32'hFFFF_FFFF)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Stand-in for the shared execute-stage ALU
  assign bus.alu_outputPort = (bus.alu_aluop == ALU_SUB) ? bus.alu_portA - bus.alu_portB :
                              (bus.alu_aluop == ALU_ADD) ? bus.alu_portA + bus.alu_portB : 32'd0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
    int          lat;
    int          start_cyc;
  } sb_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  sb_t         sbq[$];
  sb_t         mon_e;
  vec_t        vt[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic        last_div0 = 1'b0;
  logic [31:0] last_hi   = 32'd0;
  logic [31:0] last_lo   = 32'd0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h, required %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (nRST && bus.done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'(1), 64'(0));
      end else begin
        mon_e = sbq.pop_front();
        chk("hi", 64'(bus.hi), 64'(mon_e.hi));
        chk("lo", 64'(bus.lo), 64'(mon_e.lo));
        chk("div0", 64'(bus.div0), 64'(mon_e.div0));
        chk("latency", 64'(cyc - mon_e.start_cyc + 1), 64'(mon_e.lat));
        chk("busy_at_done", 64'(bus.busy), 64'(1));
      end
    end
  end

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] r;
    if (op[0] && b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (SGN && op[1]) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      if (op[0]) begin
        sq = sa / sb;
        sr = sa % sb;
        r  = {sr[31:0], sq[31:0]};
      end else begin
        r = sa * sb;
      end
    end else begin
      if (op[0]) r = {a % b, a / b};
      else       r = {32'd0, a} * {32'd0, b};
    end
    return r;
  endfunction

  task automatic add_vec(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo;
    vt.push_back(v);
  endtask

  // Drives one request and queues its expected result; returns in the first busy cycle
  task automatic issue_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] ehi, input logic [31:0] elo);
    sb_t e;
    @(negedge CLK);
    bus.start = 1'b1; bus.op = op; bus.opA = a; bus.opB = b;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    if (op[0]) last_div0 = (b == 32'd0);
    e.hi = ehi; e.lo = elo; e.div0 = last_div0;
    e.lat = (op[0] && b == 32'd0) ? 1 : ((SGN && op[1]) ? 37 : 33);
    e.start_cyc = cyc;
    last_hi = ehi; last_lo = elo;
    sbq.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("drained", 64'(sbq.size()), 64'(0));
    sbq.delete();
    @(negedge CLK);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo);
    issue_start(op, a, b, ehi, elo);
    wait_drain();
  endtask

  initial begin
    logic [63:0] m;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    nRST = 1'b0;
    bus.start = 1'b0; bus.kill = 1'b0; bus.op = 2'b00; bus.opA = 32'd0; bus.opB = 32'd0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_div0", 64'(bus.div0), 64'(0));
    chk("rst_hi", 64'(bus.hi), 64'(0));
    chk("rst_lo", 64'(bus.lo), 64'(0));
    chk("rst_aluop", 64'(bus.alu_aluop), 64'(ALU_ADD));
    chk("rst_portA", 64'(bus.alu_portA), 64'(0));
    chk("rst_portB", 64'(bus.alu_portB), 64'(0));
    nRST = 1'b1;
    @(negedge CLK);

    add_vec(2'b00, 32'd7, 32'd6, 32'd0, 32'd42);
    add_vec(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    add_vec(2'b01, 32'd100, 32'd7, 32'd2, 32'd14);
    add_vec(2'b01, 32'h8000_0001, 32'd3, 32'd0, 32'h2AAA_AAAB);
    add_vec(2'b01, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    add_vec(2'b01, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF);
    add_vec(2'b01, 32'd7, 32'hFFFF_FFFF, 32'd7, 32'd0);
    add_vec(2'b00, 32'h8000_0000, 32'd2, 32'd1, 32'd0);
    add_vec(2'b11, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
`ifdef SIGNED_MULDIV_EN
    add_vec(2'b10, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    add_vec(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    add_vec(2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    add_vec(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    add_vec(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
`else
    add_vec(2'b10, 32'd7, 32'd6, 32'd0, 32'd42);
    add_vec(2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
`endif
    for (int i = 0; i < vt.size(); i++) issue(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo);

    chk("idle_aluop", 64'(bus.alu_aluop), 64'(ALU_ADD));
    chk("idle_portA", 64'(bus.alu_portA), 64'(0));
    chk("idle_portB", 64'(bus.alu_portB), 64'(0));

    // start while busy must not replace or queue behind the running op
    issue_start(2'b00, 32'd9, 32'd9, 32'd0, 32'd81);
    repeat (5) @(negedge CLK);
    bus.start = 1'b1; bus.op = 2'b01; bus.opA = 32'd1; bus.opB = 32'd0;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    wait_drain();

    // kill in RUN: op dropped, results held, then a fresh op completes
    @(negedge CLK);
    bus.start = 1'b1; bus.op = 2'b00; bus.opA = 32'd5; bus.opB = 32'd5;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    bus.kill = 1'b1;
    @(posedge CLK); #1;
    bus.kill = 1'b0;
    chk("kill_busy", 64'(bus.busy), 64'(0));
    chk("kill_hi_held", 64'(bus.hi), 64'(last_hi));
    chk("kill_lo_held", 64'(bus.lo), 64'(last_lo));
    repeat (40) @(negedge CLK);
    issue(2'b00, 32'd3, 32'd3, 32'd0, 32'd9);

    // kill together with start in IDLE: request ignored
    @(negedge CLK);
    bus.start = 1'b1; bus.kill = 1'b1; bus.op = 2'b00; bus.opA = 32'd2; bus.opB = 32'd2;
    @(posedge CLK); #1;
    bus.start = 1'b0; bus.kill = 1'b0;
    chk("kill_start_busy", 64'(bus.busy), 64'(0));
    repeat (3) @(negedge CLK);

    // kill arriving in DONE: done still wins
    issue_start(2'b01, 32'd8, 32'd0, 32'd8, 32'hFFFF_FFFF);
    bus.kill = 1'b1;
    wait_drain();
    bus.kill = 1'b0;
    chk("post_done_busy", 64'(bus.busy), 64'(0));

    // asynchronous reset mid-op: op dropped, outputs cleared
    @(negedge CLK);
    bus.start = 1'b1; bus.op = 2'b00; bus.opA = 32'd11; bus.opB = 32'd13;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    repeat (5) @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'(0));
    chk("arst_hi", 64'(bus.hi), 64'(0));
    chk("arst_div0", 64'(bus.div0), 64'(0));
    last_div0 = 1'b0; last_hi = 32'd0; last_lo = 32'd0;
    @(negedge CLK);
    nRST = 1'b1;
    repeat (40) @(negedge CLK);

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      m   = model(rop, ra, rb);
      issue(rop, ra, rb, m[63:32], m[31:0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
